adc_spi_model: RTL and testbench

ADC_SPI_MODEL -- requirements
Module: adc_spi_model

---
 rtl/adc_spi_model.sv | 170 +++++++++++++++++
 tb/tb_adc_spi_model.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_model.sv
// Behavioural SPI slave that mimics a multi-channel ADC: 16-bit mode-0 frames,
// one-frame pipelined channel readback, sticky error flags and a frame counter.
module adc_spi_model #(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     SS_n,
    input  logic                     SCLK,
    input  logic                     MOSI,
    output logic                     MISO,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic                     auto_inc,
    input  logic                     err_clr,
    output logic                     rdy,
    output logic [2:0]               cur_ch,
    output logic                     bad_ch,
    output logic                     frame_err,
    output logic [15:0]              frame_cnt
);

    // state    | meaning
    // IDLE     | waiting for an armed SS_n fall
    // SHIFT    | frame in progress, shifting command in / response out
    // DONE     | single cycle: rdy, frame count, channel pointer update
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [3:0] NUM_CH_L = 4'(NUM_CH);
    localparam logic [2:0] LAST_CH  = 3'(NUM_CH - 1);

    logic [2:0]  ss_q, ss_d;
    logic [2:0]  sclk_q, sclk_d;
    logic [1:0]  mosi_q, mosi_d;
    logic [1:0]  fill_q, fill_d;
    logic        arm_q, arm_d;
    logic [1:0]  state_q, state_d;
    logic [15:0] cmd_q, cmd_d;
    logic [15:0] resp_q, resp_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic        rdy_q, rdy_d;
    logic [2:0]  cur_ch_q, cur_ch_d;
    logic        bad_ch_q, bad_ch_d;
    logic        frame_err_q, frame_err_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    logic              ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic              bad_set, ferr_set;
    logic [DATA_W-1:0] ch_sel;
    logic [15:0]       resp_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            ss_q        <= 3'b111;
            sclk_q      <= 3'b000;
            mosi_q      <= 2'b00;
            fill_q      <= 2'b00;
            arm_q       <= 1'b0;
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            resp_q      <= '0;
            bit_cnt_q   <= '0;
            rdy_q       <= 1'b0;
            cur_ch_q    <= '0;
            bad_ch_q    <= 1'b0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            ss_q        <= ss_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            fill_q      <= fill_d;
            arm_q       <= arm_d;
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            resp_q      <= resp_d;
            bit_cnt_q   <= bit_cnt_d;
            rdy_q       <= rdy_d;
            cur_ch_q    <= cur_ch_d;
            bad_ch_q    <= bad_ch_d;
            frame_err_q <= frame_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Bit 1 of each chain is the synchronised level, bit 2 its previous value.
    assign ss_fall   =  ss_q[2]   & ~ss_q[1];
    assign ss_rise   = ~ss_q[2]   &  ss_q[1];
    assign sclk_rise = ~sclk_q[2] &  sclk_q[1];
    assign sclk_fall =  sclk_q[2] & ~sclk_q[1];

    always_comb begin
        ch_sel = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (cur_ch_q == 3'(k)) ch_sel = ch_data[k*DATA_W +: DATA_W];
        end
        resp_load = '0;
        resp_load[DATA_W-1:0] = ch_sel;
    end

    always_comb begin
        ss_d        = {ss_q[1:0], SS_n};
        sclk_d      = {sclk_q[1:0], SCLK};
        mosi_d      = {mosi_q[0], MOSI};
        fill_d      = {fill_q[0], 1'b1};
        // A slave select still held low across reset must not look like a new frame.
        arm_d       = arm_q | (fill_q[1] & ss_q[1]);
        state_d     = state_q;
        cmd_d       = cmd_q;
        resp_d      = resp_q;
        bit_cnt_d   = bit_cnt_q;
        rdy_d       = 1'b0;
        cur_ch_d    = cur_ch_q;
        frame_cnt_d = frame_cnt_q;
        bad_set     = 1'b0;
        ferr_set    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ss_fall && arm_q) begin
                    state_d   = ST_SHIFT;
                    resp_d    = resp_load;
                    bit_cnt_d = '0;
                end
            end
            ST_SHIFT: begin
                if (ss_rise) begin
                    if (bit_cnt_q == 5'd16) begin
                        state_d = ST_DONE;
                        rdy_d   = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                        ferr_set = 1'b1;
                    end
                end else if (!ss_q[1]) begin
                    if (sclk_rise) begin
                        cmd_d = {cmd_q[14:0], mosi_q[1]};
                        if (bit_cnt_q != 5'd16) bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                    if (sclk_fall) resp_d = {resp_q[14:0], 1'b0};
                end
            end
            ST_DONE: begin
                state_d     = ST_IDLE;
                frame_cnt_d = frame_cnt_q + 16'd1;
                if (auto_inc) begin
                    cur_ch_d = (cur_ch_q == LAST_CH) ? 3'd0 : cur_ch_q + 3'd1;
                end else if ({1'b0, cmd_q[13:11]} >= NUM_CH_L) begin
                    bad_set = 1'b1;
                end else begin
                    cur_ch_d = cmd_q[13:11];
                end
            end
            default: state_d = ST_IDLE;
        endcase

        bad_ch_d    = bad_set  | (bad_ch_q    & ~err_clr);
        frame_err_d = ferr_set | (frame_err_q & ~err_clr);
    end

    assign MISO      = ~ss_q[1] & resp_q[15];
    assign rdy       = rdy_q;
    assign cur_ch    = cur_ch_q;
    assign bad_ch    = bad_ch_q;
    assign frame_err = frame_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_adc_spi_model.sv
// Directed bench for adc_spi_model: four instances cover the default,
// reduced-channel, auto-increment and 16-bit configurations.
module tb_adc_spi_model;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ss_n     [4];
    logic        sclk     [4];
    logic        mosi     [4];
    logic        miso     [4];
    logic        auto_inc [4];
    logic        err_clr  [4];
    logic        rdy      [4];
    logic [2:0]  cur_ch   [4];
    logic        bad_ch   [4];
    logic        ferr     [4];
    logic [15:0] fcnt     [4];
    int          rdy_cnt  [4];

    logic [95:0] ch_data0;
    logic [71:0] ch_data1;
    logic [35:0] ch_data2;
    logic [31:0] ch_data3;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    adc_spi_model #(.NUM_CH(8), .DATA_W(12)) u_dut0 (
        .clk(clk), .rst(rst), .SS_n(ss_n[0]), .SCLK(sclk[0]), .MOSI(mosi[0]), .MISO(miso[0]),
        .ch_data(ch_data0), .auto_inc(auto_inc[0]), .err_clr(err_clr[0]), .rdy(rdy[0]),
        .cur_ch(cur_ch[0]), .bad_ch(bad_ch[0]), .frame_err(ferr[0]), .frame_cnt(fcnt[0]));

    adc_spi_model #(.NUM_CH(6), .DATA_W(12)) u_dut1 (
        .clk(clk), .rst(rst), .SS_n(ss_n[1]), .SCLK(sclk[1]), .MOSI(mosi[1]), .MISO(miso[1]),
        .ch_data(ch_data1), .auto_inc(auto_inc[1]), .err_clr(err_clr[1]), .rdy(rdy[1]),
        .cur_ch(cur_ch[1]), .bad_ch(bad_ch[1]), .frame_err(ferr[1]), .frame_cnt(fcnt[1]));

    adc_spi_model #(.NUM_CH(3), .DATA_W(12)) u_dut2 (
        .clk(clk), .rst(rst), .SS_n(ss_n[2]), .SCLK(sclk[2]), .MOSI(mosi[2]), .MISO(miso[2]),
        .ch_data(ch_data2), .auto_inc(auto_inc[2]), .err_clr(err_clr[2]), .rdy(rdy[2]),
        .cur_ch(cur_ch[2]), .bad_ch(bad_ch[2]), .frame_err(ferr[2]), .frame_cnt(fcnt[2]));

    adc_spi_model #(.NUM_CH(2), .DATA_W(16)) u_dut3 (
        .clk(clk), .rst(rst), .SS_n(ss_n[3]), .SCLK(sclk[3]), .MOSI(mosi[3]), .MISO(miso[3]),
        .ch_data(ch_data3), .auto_inc(auto_inc[3]), .err_clr(err_clr[3]), .rdy(rdy[3]),
        .cur_ch(cur_ch[3]), .bad_ch(bad_ch[3]), .frame_err(ferr[3]), .frame_cnt(fcnt[3]));

    // Counting high cycles also confirms rdy is a single-cycle pulse.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) if (rdy[i] === 1'b1) rdy_cnt[i]++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_frame(input int idx, input logic [15:0] cmd, input int nrise,
                             output logic [15:0] resp);
        int off;
        resp = '0;
        off  = nrise - 16;
        ss_n[idx] = 1'b0;
        tick(4);
        for (int i = 0; i < nrise; i++) begin
            if (off > 0 && i < off)  mosi[idx] = 1'b1;
            else if (off > 0)        mosi[idx] = cmd[15 - (i - off)];
            else                     mosi[idx] = cmd[15 - i];
            tick(4);
            sclk[idx] = 1'b1;
            resp = {resp[14:0], miso[idx]};
            tick(4);
            sclk[idx] = 1'b0;
        end
        tick(4);
        mosi[idx] = 1'b0;
        ss_n[idx] = 1'b1;
        tick(10);
    endtask

    task automatic pulse_err_clr(input int idx);
        err_clr[idx] = 1'b1;
        tick(1);
        err_clr[idx] = 1'b0;
        tick(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r;
        logic [15:0] exp_resp [4];
        logic [2:0]  exp_cur  [4];
        int          rc;

        exp_resp[0] = 16'h0A01; exp_resp[1] = 16'h0A02; exp_resp[2] = 16'h0A03; exp_resp[3] = 16'h0A01;
        exp_cur[0]  = 3'd1;     exp_cur[1]  = 3'd2;     exp_cur[2]  = 3'd0;     exp_cur[3]  = 3'd1;

        for (int i = 0; i < 4; i++) begin
            ss_n[i] = 1'b1; sclk[i] = 1'b0; mosi[i] = 1'b0;
            auto_inc[i] = 1'b0; err_clr[i] = 1'b0; rdy_cnt[i] = 0;
        end
        auto_inc[2] = 1'b1;
        ch_data0 = '0;
        ch_data0[0*12 +: 12] = 12'hC00;
        ch_data0[3*12 +: 12] = 12'h333;
        ch_data0[4*12 +: 12] = 12'hBF0;
        ch_data0[6*12 +: 12] = 12'h666;
        ch_data1 = '0;
        ch_data1[0*12 +: 12] = 12'h111;
        ch_data1[5*12 +: 12] = 12'h155;
        ch_data2 = {12'hA03, 12'hA02, 12'hA01};
        ch_data3 = {16'h5555, 16'hFFFF};

        tick(3);
        rst = 1'b0;
        tick(6);

        check("reset cur_ch",    32'(cur_ch[0]), 32'd0);
        check("reset rdy",       32'(rdy[0]),    32'd0);
        check("reset bad_ch",    32'(bad_ch[0]), 32'd0);
        check("reset frame_err", 32'(ferr[0]),   32'd0);
        check("reset frame_cnt", 32'(fcnt[0]),   32'd0);
        check("reset miso",      32'(miso[0]),   32'd0);

        // Pipelined readback: frame 1 selects ch4, frame 2 returns it.
        spi_frame(0, 16'h2000, 16, r);
        check("f1 resp",   32'(r),         32'h0C00);
        check("f1 cur_ch", 32'(cur_ch[0]), 32'd4);
        check("f1 cnt",    32'(fcnt[0]),   32'd1);
        check("f1 rdy",    32'(rdy_cnt[0]), 32'd1);
        spi_frame(0, 16'h0000, 16, r);
        check("f2 resp",   32'(r),         32'h0BF0);
        check("f2 cur_ch", 32'(cur_ch[0]), 32'd0);
        check("f2 cnt",    32'(fcnt[0]),   32'd2);
        check("f2 rdy",    32'(rdy_cnt[0]), 32'd2);

        // Aborted frame after 9 bits.
        spi_frame(0, 16'h1800, 9, r);
        check("abort frame_err", 32'(ferr[0]),    32'd1);
        check("abort rdy",       32'(rdy_cnt[0]), 32'd2);
        check("abort cnt",       32'(fcnt[0]),    32'd2);
        check("abort cur_ch",    32'(cur_ch[0]),  32'd0);
        check("abort miso idle", 32'(miso[0]),    32'd0);
        spi_frame(0, 16'h1800, 16, r);
        check("post-abort resp",   32'(r),          32'h0C00);
        check("post-abort cur_ch", 32'(cur_ch[0]),  32'd3);
        check("post-abort cnt",    32'(fcnt[0]),    32'd3);
        check("post-abort rdy",    32'(rdy_cnt[0]), 32'd3);

        // 20 clocks: only the last 16 MOSI bits form the command.
        spi_frame(0, 16'h3000, 20, r);
        check("long cur_ch", 32'(cur_ch[0]),  32'd6);
        check("long cnt",    32'(fcnt[0]),    32'd4);
        check("long rdy",    32'(rdy_cnt[0]), 32'd4);

        // SCLK toggling with SS_n high must be ignored.
        for (int i = 0; i < 6; i++) begin
            mosi[0] = 1'b1; sclk[0] = 1'b1; tick(4);
            sclk[0] = 1'b0; tick(4);
        end
        mosi[0] = 1'b0;
        check("idle sclk cnt",  32'(fcnt[0]), 32'd4);
        spi_frame(0, 16'h0000, 16, r);
        check("f4 resp ch6",    32'(r),          32'h0666);
        check("f4 cnt",         32'(fcnt[0]),    32'd5);
        check("sticky ferr",    32'(ferr[0]),    32'd1);
        pulse_err_clr(0);
        check("err_clr ferr",   32'(ferr[0]),    32'd0);

        // Reduced channel count: out-of-range selects flag bad_ch.
        spi_frame(1, 16'h3800, 16, r);
        check("nch6 resp",     32'(r),          32'h0111);
        check("nch6 bad_ch",   32'(bad_ch[1]),  32'd1);
        check("nch6 cur_ch",   32'(cur_ch[1]),  32'd0);
        check("nch6 rdy",      32'(rdy_cnt[1]), 32'd1);
        pulse_err_clr(1);
        check("nch6 clr",      32'(bad_ch[1]),  32'd0);
        spi_frame(1, 16'h2800, 16, r);
        check("nch6 ch5 cur",  32'(cur_ch[1]),  32'd5);
        check("nch6 ch5 bad",  32'(bad_ch[1]),  32'd0);
        spi_frame(1, 16'h3000, 16, r);
        check("nch6 ch6 resp", 32'(r),          32'h0155);
        check("nch6 ch6 bad",  32'(bad_ch[1]),  32'd1);
        check("nch6 ch6 cur",  32'(cur_ch[1]),  32'd5);

        // Auto-increment with three channels.
        for (int f = 0; f < 4; f++) begin
            spi_frame(2, 16'h3800, 16, r);
            check($sformatf("auto resp %0d", f), 32'(r),         32'(exp_resp[f]));
            check($sformatf("auto cur %0d", f),  32'(cur_ch[2]), 32'(exp_cur[f]));
        end
        check("auto bad_ch", 32'(bad_ch[2]), 32'd0);

        // Response is latched at frame start.
        fork
            spi_frame(3, 16'h0000, 16, r);
            begin
                tick(40);
                ch_data3[15:0] = 16'h1234;
            end
        join
        check("latch resp",   32'(r),         32'hFFFF);
        spi_frame(3, 16'h0800, 16, r);
        check("latch next",   32'(r),         32'h1234);
        check("w16 cur_ch",   32'(cur_ch[3]), 32'd1);
        check("w16 cnt",      32'(fcnt[3]),   32'd2);
        spi_frame(3, 16'h0000, 5, r);
        check("w16 abort",    32'(ferr[3]),   32'd1);

        // Reset in the middle of a frame.
        rc = rdy_cnt[3];
        fork
            spi_frame(3, 16'h0000, 16, r);
            begin
                tick(60);
                rst = 1'b1;
                tick(2);
                rst = 1'b0;
                tick(1);
                check("rst cur_ch", 32'(cur_ch[3]), 32'd0);
                check("rst cnt",    32'(fcnt[3]),   32'd0);
                check("rst ferr",   32'(ferr[3]),   32'd0);
                check("rst bad",    32'(bad_ch[3]), 32'd0);
                check("rst rdy",    32'(rdy[3]),    32'd0);
                check("rst miso",   32'(miso[3]),   32'd0);
            end
        join
        tick(10);
        check("rst no rdy",   32'(rdy_cnt[3]), 32'(rc));
        check("rst no ferr",  32'(ferr[3]),    32'd0);
        check("rst no cnt",   32'(fcnt[3]),    32'd0);
        spi_frame(3, 16'h0000, 16, r);
        check("rst fresh resp", 32'(r),       32'h1234);
        check("rst fresh cnt",  32'(fcnt[3]), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
